// File: rtl/step_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_tick_sequencer
// Purpose  : Consumer side of the periodic toggle-tick generator. Detects each
//            start/end toggle pair, divides ticks by a speed setting, and
//            issues one step request per game step to the movement logic over
//            a req/ack handshake. Flags pair mismatch, dropped steps and a
//            stalled tick source.
// Options  : STEP_TIMEOUT_EN - when defined, a pending step request is
//            abandoned after ACK_TMO cycles without step_ack and ack_tmo is
//            set. When undefined, BUSY waits forever and ack_tmo is tied 0.
// Ports    :
//   CLK_40M     in   1   system clock, rising edge
//   RST         in   1   synchronous active-high reset
//   start_tgl   in   1   tick toggle (idle level 1 out of reset)
//   end_tgl     in   1   companion toggle (idle level 0 out of reset)
//   pause       in   1   1 = ignore ticks for stepping, hold divider
//   speed       in   2   one step every speed+1 ticks
//   step_ack    in   1   movement logic accepted the step
//   ovr_clr     in   1   one-cycle pulse clears overrun
//   step_req    out  1   step request, held until acked
//   step_cnt    out  16  completed steps, wraps
//   tick_pulse  out  1   one-cycle pulse per detected toggle
//   overrun     out  1   sticky: a step event was dropped
//   tick_err    out  1   sticky: start/end toggles disagreed
//   stall       out  1   no tick for TIMEOUT_CYC cycles
//   ack_tmo     out  1   sticky: step abandoned on ack timeout
// Revision : 1.0 - initial release
// ============================================================================
module step_tick_sequencer #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
  parameter logic [15:0] ACK_TMO     = 16'd1024
) (
  input  logic        CLK_40M,
  input  logic        RST,
  input  logic        start_tgl,
  input  logic        end_tgl,
  input  logic        pause,
  input  logic [1:0]  speed,
  input  logic        step_ack,
  input  logic        ovr_clr,
  output logic        step_req,
  output logic [15:0] step_cnt,
  output logic        tick_pulse,
  output logic        overrun,
  output logic        tick_err,
  output logic        stall,
  output logic        ack_tmo
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state, state_nxt;

  logic        start_prev;
  logic        end_prev;
  logic        t_s;
  logic        t_e;
  logic [1:0]  div_cnt;
  logic [31:0] wd_cnt;
  logic        step_evt;

  logic        req_nxt;
  logic [15:0] cnt_nxt;
  logic        ovr_nxt;
  logic        tmo_nxt;

  // --------------------------------------------------------------------------
  // Toggle detection. The generator's tick is defined by start_tgl; end_tgl
  // only serves as a consistency check.
  // --------------------------------------------------------------------------
  assign t_s = start_tgl ^ start_prev;
  assign t_e = end_tgl ^ end_prev;

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      start_prev <= 1'b1;
      end_prev   <= 1'b0;
      tick_pulse <= 1'b0;
      tick_err   <= 1'b0;
    end else begin
      start_prev <= start_tgl;
      end_prev   <= end_tgl;
      tick_pulse <= t_s;
      if (t_s != t_e) begin
        tick_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Speed divider, driven from the registered tick so that the step request
  // appears two cycles after the input toggle. The >= compare lets a speed
  // reduction mid-count fire on the next tick instead of wrapping.
  // --------------------------------------------------------------------------
  assign step_evt = tick_pulse & ~pause & (div_cnt >= speed);

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      div_cnt <= 2'd0;
    end else if (tick_pulse && !pause) begin
      if (div_cnt >= speed) begin
        div_cnt <= 2'd0;
      end else begin
        div_cnt <= div_cnt + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog. Cleared on the raw toggle so that stall (registered from the
  // old count) falls one cycle after tick_pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      wd_cnt <= 32'd0;
      stall  <= 1'b0;
    end else begin
      stall <= (wd_cnt == TIMEOUT_CYC);
      if (t_s) begin
        wd_cnt <= 32'd0;
      end else if (wd_cnt != TIMEOUT_CYC) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional ack timeout counter
  // --------------------------------------------------------------------------
`ifdef STEP_TIMEOUT_EN
  logic [15:0] ack_cnt, ack_cnt_nxt;

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      ack_cnt <= 16'd0;
    end else begin
      ack_cnt <= ack_cnt_nxt;
    end
  end
`else
  logic unused_ack_tmo;
  assign unused_ack_tmo = ^ACK_TMO;
`endif

  // --------------------------------------------------------------------------
  // Handshake FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      state    <= S_IDLE;
      step_req <= 1'b0;
      step_cnt <= 16'd0;
      overrun  <= 1'b0;
      ack_tmo  <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_req <= req_nxt;
      step_cnt <= cnt_nxt;
      overrun  <= ovr_nxt;
      ack_tmo  <= tmo_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    req_nxt     = step_req;
    cnt_nxt     = step_cnt;
    tmo_nxt     = ack_tmo;
`ifdef STEP_TIMEOUT_EN
    ack_cnt_nxt = ack_cnt;
`endif

    case (state)
      S_IDLE: begin
        // step_ack is ignored here; only a step event leaves IDLE.
        if (step_evt) begin
          req_nxt   = 1'b1;
          state_nxt = S_BUSY;
`ifdef STEP_TIMEOUT_EN
          ack_cnt_nxt = 16'd0;
`endif
        end
      end

      S_BUSY: begin
        if (step_ack) begin
          // Completion beats a timeout landing in the same cycle.
          req_nxt   = 1'b0;
          cnt_nxt   = step_cnt + 16'd1;
          state_nxt = S_IDLE;
        end
`ifdef STEP_TIMEOUT_EN
        else if (ack_cnt == ACK_TMO - 16'd1) begin
          req_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + 16'd1;
        end
`endif
      end

      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    // A step event that cannot be accepted is dropped. A fresh drop wins
    // over a clear arriving in the same cycle.
    if (step_evt && (state == S_BUSY)) begin
      ovr_nxt = 1'b1;
    end else if (ovr_clr) begin
      ovr_nxt = 1'b0;
    end else begin
      ovr_nxt = overrun;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_tick_sequencer
// Purpose  : Self-checking bench for step_tick_sequencer. Directed tick
//            sequences push the expected step_cnt of each completion into a
//            queue; a monitor pops and compares on every accepted handshake.
//            An ack responder answers step_req after a programmable delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_tick_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tgl;
  logic        end_tgl;
  logic        pause;
  logic [1:0]  speed;
  logic        step_ack;
  logic        ovr_clr;
  logic        step_req;
  logic [15:0] step_cnt;
  logic        tick_pulse;
  logic        overrun;
  logic        tick_err;
  logic        stall;
  logic        ack_tmo;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  bit          ack_en = 1'b1;
  int          ack_delay = 0;

  always #5 clk = ~clk;

  step_tick_sequencer #(
    .TIMEOUT_CYC(32'd100),
    .ACK_TMO    (16'd16)
  ) dut (
    .CLK_40M   (clk),
    .RST       (rst),
    .start_tgl (start_tgl),
    .end_tgl   (end_tgl),
    .pause     (pause),
    .speed     (speed),
    .step_ack  (step_ack),
    .ovr_clr   (ovr_clr),
    .step_req  (step_req),
    .step_cnt  (step_cnt),
    .tick_pulse(tick_pulse),
    .overrun   (overrun),
    .tick_err  (tick_err),
    .stall     (stall),
    .ack_tmo   (ack_tmo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_both();
    start_tgl = ~start_tgl;
    end_tgl   = ~end_tgl;
  endtask

  // Ack responder: raises step_ack for one cycle, ack_delay cycles after it
  // first sees step_req.
  initial begin : ack_responder
    int wcnt;
    wcnt = 0;
    step_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (step_ack) begin
        step_ack = 1'b0;
        wcnt = 0;
      end else if (step_req && ack_en) begin
        if (wcnt >= ack_delay) begin
          step_ack = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: every accepted handshake must match the next queued count.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (step_req === 1'b1 && step_ack === 1'b1 && rst === 1'b0) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got step_cnt %0h, expected no step", step_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("step_cnt_on_ack", {16'd0, step_cnt}, {16'd0, e});
        end
      end
    end
  end

  initial begin : stimulus
    int nexp;
    int hi_cnt;
    rst = 1'b1;
    start_tgl = 1'b1;
    end_tgl = 1'b0;
    pause = 1'b0;
    speed = 2'd0;
    ovr_clr = 1'b0;
    cyc(3);
    chk("reset_step_req", {31'd0, step_req}, 0);
    chk("reset_step_cnt", {16'd0, step_cnt}, 0);
    chk("reset_tick_pulse", {31'd0, tick_pulse}, 0);
    rst = 1'b0;
    cyc(2);

    // 1: speed 0, ack 3 cycles after req, tick every 10 cycles
    ack_delay = 3;
    toggle_both();
    exp_q.push_back(16'd1);
    cyc(1);
    chk("tick_pulse_hi", {31'd0, tick_pulse}, 1);
    chk("req_not_yet", {31'd0, step_req}, 0);
    cyc(1);
    chk("tick_pulse_one_wide", {31'd0, tick_pulse}, 0);
    chk("req_latency_2", {31'd0, step_req}, 1);
    cyc(8);
    for (int i = 2; i <= 5; i++) begin
      toggle_both();
      exp_q.push_back(16'(i));
      cyc(10);
    end
    chk("t1_step_cnt", {16'd0, step_cnt}, 5);
    chk("t1_tick_err", {31'd0, tick_err}, 0);
    chk("t1_overrun", {31'd0, overrun}, 0);

    // 2: speed 2, immediate ack; then pause over ticks 4-6
    speed = 2'd2;
    ack_delay = 0;
    nexp = 5;
    for (int i = 1; i <= 9; i++) begin
      toggle_both();
      if (i % 3 == 0) begin
        nexp++;
        exp_q.push_back(16'(nexp));
      end
      cyc(10);
    end
    chk("t2_step_cnt", {16'd0, step_cnt}, 8);
    for (int i = 1; i <= 9; i++) begin
      pause = (i >= 4 && i <= 6);
      toggle_both();
      if (i == 3) exp_q.push_back(16'd9);
      if (i == 9) exp_q.push_back(16'd10);
      cyc(10);
    end
    pause = 1'b0;
    chk("t2_pause_step_cnt", {16'd0, step_cnt}, 10);

    // 3: overrun with ack withheld, then clear
    start_tgl = 1'b1;
    end_tgl = 1'b0;
    rst = 1'b1;
    cyc(2);
    chk("rst_step_cnt", {16'd0, step_cnt}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_ack_tmo", {31'd0, ack_tmo}, 0);
    rst = 1'b0;
    speed = 2'd0;
    ack_en = 1'b0;
    cyc(2);
    toggle_both();
    cyc(10);
    chk("t3_req_held", {31'd0, step_req}, 1);
    toggle_both();
    cyc(10);
    chk("t3_overrun_set", {31'd0, overrun}, 1);
    chk("t3_step_cnt_0", {16'd0, step_cnt}, 0);
    exp_q.push_back(16'd1);
    ack_en = 1'b1;
    cyc(10);
    chk("t3_step_cnt_1", {16'd0, step_cnt}, 1);
    chk("t3_overrun_sticky", {31'd0, overrun}, 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("t3_overrun_clr", {31'd0, overrun}, 0);
    // Clear coinciding with a new drop: the drop wins.
    ack_en = 1'b0;
    toggle_both();
    cyc(10);
    toggle_both();
    cyc(1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("t3_set_beats_clr", {31'd0, overrun}, 1);
    exp_q.push_back(16'd2);
    ack_en = 1'b1;
    cyc(10);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;

    // 4: start_tgl alone -> sticky tick_err
    start_tgl = ~start_tgl;
    exp_q.push_back(16'd3);
    cyc(2);
    chk("t4_tick_err", {31'd0, tick_err}, 1);
    cyc(8);
    toggle_both();
    exp_q.push_back(16'd4);
    cyc(10);
    chk("t4_tick_err_sticky", {31'd0, tick_err}, 1);
    chk("t4_step_cnt", {16'd0, step_cnt}, 4);

    // 5: watchdog with TIMEOUT_CYC = 100
    start_tgl = 1'b1;
    end_tgl = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(98);
    chk("t5_tick_err_cleared", {31'd0, tick_err}, 0);
    chk("t5_no_stall_early", {31'd0, stall}, 0);
    cyc(4);
    chk("t5_stall_set", {31'd0, stall}, 1);
    cyc(18);
    chk("t5_stall_held", {31'd0, stall}, 1);
    toggle_both();
    exp_q.push_back(16'd1);
    cyc(1);
    chk("t5_stall_tick_cycle", {31'd0, stall}, 1);
    cyc(1);
    chk("t5_stall_dropped", {31'd0, stall}, 0);
    cyc(8);

    // Reset mid-handshake drops step_req, nothing counted
    ack_en = 1'b0;
    toggle_both();
    cyc(4);
    chk("t5_req_pending", {31'd0, step_req}, 1);
    start_tgl = 1'b1;
    end_tgl = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_drops_req", {31'd0, step_req}, 0);
    chk("t5_rst_step_cnt", {16'd0, step_cnt}, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);

`ifdef STEP_TIMEOUT_EN
    // 6: ack timeout after 16 BUSY cycles
    toggle_both();
    cyc(2);
    hi_cnt = 0;
    while (step_req && hi_cnt < 40) begin
      hi_cnt++;
      cyc(1);
    end
    chk("t6_req_high_cycles", hi_cnt, 16);
    chk("t6_ack_tmo", {31'd0, ack_tmo}, 1);
    chk("t6_step_cnt", {16'd0, step_cnt}, 0);
    toggle_both();
    cyc(4);
    start_tgl = 1'b1;
    end_tgl = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_drops_req", {31'd0, step_req}, 0);
    cyc(1);
    rst = 1'b0;
`else
    hi_cnt = 0;
    toggle_both();
    cyc(30);
    if (step_req) hi_cnt = 1;
    chk("t6_req_waits", hi_cnt, 1);
    chk("t6_ack_tmo_tied", {31'd0, ack_tmo}, 0);
`endif
    ack_en = 1'b0;
    cyc(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
